// File: rtl/rr_pipe_arbiter.sv
// rr_pipe_arbiter: round-robin arbiter feeding one elastic output buffer.
// Optional burst lock enabled by defining RR_PIPE_ARBITER_BURST_LOCK_EN.
module rr_pipe_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 16,
  parameter bit FULL_THROUGHPUT = 1'b1,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]            req_last_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [DATA_WIDTH-1:0]         out_data_o,
  output logic [ID_W-1:0]               out_id_o,
  output logic                          out_last_o
);
  logic                  full_q;
  logic [ID_W-1:0]       ptr_q, id_q, gnt;
  logic [DATA_WIDTH-1:0] data_q, gnt_data;
  logic                  last_q, found, write_en, accept;
  logic [ID_W:0]         sum;
`ifdef RR_PIPE_ARBITER_BURST_LOCK_EN
  logic                  lock_q;
  logic [ID_W-1:0]       lock_id_q;
`endif
  assign write_en = FULL_THROUGHPUT ? (out_ready_i | ~full_q) : ~full_q;
  // Scan from the far end so the requester closest to ptr wins.
  always_comb begin
    found = 1'b0;
    gnt = '0;
    sum = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (ID_W+1)'(k);
      sum = (sum >= (ID_W+1)'(NUM_REQ)) ? sum - (ID_W+1)'(NUM_REQ) : sum;
      if (req_valid_i[sum[ID_W-1:0]]) begin
        found = 1'b1;
        gnt = sum[ID_W-1:0];
      end
    end
`ifdef RR_PIPE_ARBITER_BURST_LOCK_EN
    if (lock_q) begin
      found = req_valid_i[lock_id_q];
      gnt = lock_id_q;
    end
`endif
  end
  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (ID_W'(i) == gnt) gnt_data = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end
  assign accept      = found & write_en & ~rst;
  assign req_ready_o = accept ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << gnt) : '0;
  // A full buffer also drains when downstream takes it and nothing refills it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 1'b0;
      ptr_q     <= '0;
      data_q    <= '0;
      id_q      <= '0;
      last_q    <= 1'b0;
`ifdef RR_PIPE_ARBITER_BURST_LOCK_EN
      lock_q    <= 1'b0;
      lock_id_q <= '0;
`endif
    end else if (accept) begin
      full_q    <= 1'b1;
      data_q    <= gnt_data;
      id_q      <= gnt;
      last_q    <= req_last_i[gnt];
      ptr_q     <= (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
`ifdef RR_PIPE_ARBITER_BURST_LOCK_EN
      lock_q    <= ~req_last_i[gnt];
      lock_id_q <= gnt;
`endif
    end else if (write_en | out_ready_i) begin
      full_q    <= 1'b0;
    end
  end
  assign out_valid_o = full_q;
  assign out_data_o  = data_q;
  assign out_id_o    = id_q;
  assign out_last_o  = last_q;
endmodule

// File: tb/tb_rr_pipe_arbiter.sv
// tb_rr_pipe_arbiter: scoreboard bench for rr_pipe_arbiter, plus a half-throughput instance.
module tb_rr_pipe_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid, hv, rdy, h_rdy, last;
  logic [63:0] dat;
  logic        oready, ov, h_ov, ol, h_ol;
  logic [15:0] od, h_od;
  logic [1:0]  oid, h_id;
  logic [31:0] q[$];
  logic [3:0]  r;
  int checks = 0, failures = 0, b1, b3;

  always #5 clk = ~clk;

  rr_pipe_arbiter dut (
    .clk(clk), .rst(rst), .req_valid_i(valid), .req_ready_o(rdy), .req_data_i(dat),
    .req_last_i(last), .out_valid_o(ov), .out_ready_i(oready), .out_data_o(od),
    .out_id_o(oid), .out_last_o(ol)
  );

  rr_pipe_arbiter #(.FULL_THROUGHPUT(1'b0)) dut_h (
    .clk(clk), .rst(rst), .req_valid_i(hv), .req_ready_o(h_rdy), .req_data_i(dat),
    .req_last_i(last), .out_valid_o(h_ov), .out_ready_i(oready), .out_data_o(h_od),
    .out_id_o(h_id), .out_last_o(h_ol)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat(input logic [1:0] id, input logic l, input logic [15:0] d);
    return {13'b0, id, l, d};
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (!rst && ov && oready) begin
      if (q.size() == 0) chk("sb_underflow", beat(oid, ol, od), 32'hFFFF_FFFF);
      else chk("sb_beat", beat(oid, ol, od), q.pop_front());
    end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    rst = 1'b1; valid = 4'hF; hv = 4'h3; oready = 1'b1; last = '0; dat = '0;
    #3;
    chk("rst_rdy", rdy, 0);
    chk("rst_h_rdy", h_rdy, 0);
    repeat (2) @(posedge clk);
    #1 valid = '0; hv = '0; rst = 1'b0;
    @(negedge clk);
    chk("rel_valid", ov, 0);
    chk("rel_rdy", rdy, 0);
    chk("rel_data", od, 0);
    chk("rel_id", oid, 0);
    chk("rel_last", ol, 0);
    chk("rel_h_valid", h_ov, 0);

    // all four valid, downstream always ready
    step();
    for (int i = 0; i < 4; i++) dat[i*16 +: 16] = 16'hC000 + 16'(i);
    valid = 4'hF;
    for (int k = 0; k < 6; k++) q.push_back(beat(2'(k % 4), 1'b0, 16'hC000 + 16'(k % 4)));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rr_rdy", rdy, 4'b0001 << (k % 4));
      if (k > 0) chk("rr_valid", ov, 1);
      step();
    end
    valid = '0;
    repeat (3) @(negedge clk);
    chk("rr_drained", q.size(), 0);
    chk("rr_empty", ov, 0);

    // single requester, downstream stalled three cycles
    step();
    oready = 1'b0; valid = 4'b0100; dat[47:32] = 16'hA5A5;
    q.push_back(beat(2'd2, 1'b0, 16'hA5A5));
    @(negedge clk);
    chk("st_rdy0", rdy, 4'b0100);
    step();
    dat[47:32] = 16'h5A5A;
    q.push_back(beat(2'd2, 1'b0, 16'h5A5A));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("st_valid", ov, 1);
      chk("st_data", od, 16'hA5A5);
      chk("st_id", oid, 2);
      chk("st_rdy", rdy, 0);
      step();
    end
    oready = 1'b1;
    @(negedge clk);
    chk("st_fill_rdy", rdy, 4'b0100);
    step();
    valid = '0;
    @(negedge clk);
    chk("st_still_full", ov, 1);
    step();
    @(negedge clk);
    chk("st_empty", ov, 0);
    chk("st_drained", q.size(), 0);

    // async reset while holding id 3, then round robin restarts at 0
    step();
    valid = 4'b1000; dat[63:48] = 16'h3333;
    @(negedge clk);
    chk("ar_rdy", rdy, 4'b1000);
    step();
    valid = '0; oready = 1'b0;
    @(negedge clk);
    chk("ar_full", ov, 1);
    chk("ar_id", oid, 3);
    #2 rst = 1'b1;
    #1;
    chk("ar_async_valid", ov, 0);
    chk("ar_async_id", oid, 0);
    chk("ar_async_data", od, 0);
    q.delete();
    step();
    rst = 1'b0; oready = 1'b1; valid = 4'hF;
    for (int i = 0; i < 4; i++) dat[i*16 +: 16] = 16'hC000 + 16'(i);
    q.push_back(beat(2'd0, 1'b0, 16'hC000));
    @(negedge clk);
    chk("ar_first_rdy", rdy, 4'b0001);
    step();
    valid = '0;
    repeat (2) @(negedge clk);
    chk("ar_drained", q.size(), 0);

    // requester 1 bursts three beats while requester 3 sends two
    step();
    dat[31:16] = 16'h1110; last[1] = 1'b0; dat[63:48] = 16'h3333; last[3] = 1'b1;
`ifdef RR_PIPE_ARBITER_BURST_LOCK_EN
    q.push_back(beat(2'd1, 1'b0, 16'h1110));
    q.push_back(beat(2'd1, 1'b0, 16'h1111));
    q.push_back(beat(2'd1, 1'b1, 16'h1112));
    q.push_back(beat(2'd3, 1'b1, 16'h3333));
    q.push_back(beat(2'd3, 1'b1, 16'h3333));
`else
    q.push_back(beat(2'd1, 1'b0, 16'h1110));
    q.push_back(beat(2'd3, 1'b1, 16'h3333));
    q.push_back(beat(2'd1, 1'b0, 16'h1111));
    q.push_back(beat(2'd3, 1'b1, 16'h3333));
    q.push_back(beat(2'd1, 1'b1, 16'h1112));
`endif
    b1 = 0; b3 = 0; valid = 4'b1010;
    for (int t = 0; t < 20 && (b1 < 3 || b3 < 2); t++) begin
      @(negedge clk);
      r = rdy;
      step();
      if (r[1]) b1++;
      if (r[3]) b3++;
      valid[1] = b1 < 3;
      valid[3] = b3 < 2;
      dat[31:16] = 16'h1110 + 16'(b1);
      last[1] = b1 == 2;
    end
    chk("bu_done", {b1[15:0], b3[15:0]}, {16'd3, 16'd2});
    valid = '0;
    repeat (3) @(negedge clk);
    chk("bu_drained", q.size(), 0);

    // half-throughput instance, requesters 0 and 1 always valid
    step();
    dat[15:0] = 16'hE000; dat[31:16] = 16'hE001; last = '0; hv = 4'b0011;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("ht_rdy", h_rdy, (k % 2) ? 4'b0000 : ((k % 4 == 0) ? 4'b0001 : 4'b0010));
      chk("ht_valid", h_ov, k % 2);
      if (k % 2) begin
        chk("ht_id", h_id, (k / 2) % 2);
        chk("ht_data", h_od, 16'hE000 + 16'((k / 2) % 2));
      end
      step();
    end
    hv = '0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
